// File: rtl/execute.sv
// EXE pipeline stage: single-cycle ALU, committed HI/LO registers and a
// multi-cycle multiply/divide engine feeding the MEM stage.
module execute #(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         EXE_valid,
  input  logic [176:0] ID_EXE_bus_r,
  input  logic         MEM_allow_in,
  input  logic         cancel,
  output logic         EXE_over,
  output logic [4:0]   EXE_wdest,
  output logic [123:0] EXE_MEM_bus
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  logic        division, divunsigned, multiply, mthi, mtlo;
  logic [13:0] alu_control;
  logic [31:0] op1, op2, store_data, pc;
  logic [4:0]  mem_control, rf_wdest;
  logic        mfhi, mflo, mtc0, mfc0;
  logic [7:0]  cp0r_addr;
  logic        syscall, break_op, eret, no_inst;
  logic        j_valid, pc_valid, is_in_delay, rf_wen;

  assign {division, divunsigned, multiply, mthi, mtlo, alu_control, op1, op2, mem_control,
          store_data, mfhi, mflo, mtc0, mfc0, cp0r_addr, syscall, break_op, eret, no_inst,
          j_valid, pc_valid, is_in_delay, rf_wen, rf_wdest, pc} = ID_EXE_bus_r;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  // Result staging: product halves, or remainder (hi) / quotient shift register (lo).
  logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic [31:0] dsr_q, dsr_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d;

  // Single-cycle ALU; one-hot select, all-zero control yields zero.
  logic [31:0] alu_res, sum, diff, sra_res;
  logic        slt_bit, sltu_bit;
  always_comb begin
    sum      = op1 + op2;
    diff     = op1 - op2;
    slt_bit  = $signed(op1) < $signed(op2);
    sltu_bit = op1 < op2;
    sra_res  = $unsigned($signed(op2) >>> op1[4:0]);
    alu_res  = ({32{alu_control[13] | alu_control[12]}} & sum)
             | ({32{alu_control[11] | alu_control[10]}} & diff)
             | ({32{alu_control[9]}} & {31'b0, slt_bit})
             | ({32{alu_control[8]}} & {31'b0, sltu_bit})
             | ({32{alu_control[7]}} & (op1 & op2))
             | ({32{alu_control[6]}} & ~(op1 | op2))
             | ({32{alu_control[5]}} & (op1 | op2))
             | ({32{alu_control[4]}} & (op1 ^ op2))
             | ({32{alu_control[3]}} & (op2 << op1[4:0]))
             | ({32{alu_control[2]}} & (op2 >> op1[4:0]))
             | ({32{alu_control[1]}} & sra_res)
             | ({32{alu_control[0]}} & {op2[15:0], 16'h0});
  end

  // Multiply operands sign- or zero-extended to 64 bits; low 64 product bits are exact.
  logic        is_signed;
  logic [63:0] mul_a, mul_b, product;
  // Restoring divide step datapath.
  logic [32:0] rem_sh, rem_sub;
  logic        q_bit;
  logic [31:0] rem_new, quo_new, abs_a, abs_b;
  always_comb begin
    is_signed = ~divunsigned;
    mul_a     = {{32{is_signed & op1[31]}}, op1};
    mul_b     = {{32{is_signed & op2[31]}}, op2};
    product   = mul_a * mul_b;
    abs_a     = (is_signed & op1[31]) ? (32'h0 - op1) : op1;
    abs_b     = (is_signed & op2[31]) ? (32'h0 - op2) : op2;
    rem_sh    = {res_hi_q, res_lo_q[31]};
    rem_sub   = rem_sh - {1'b0, dsr_q};
    q_bit     = ~rem_sub[32];
    rem_new   = q_bit ? rem_sub[31:0] : rem_sh[31:0];
    quo_new   = {res_lo_q[30:0], q_bit};
  end

  logic start, handoff;
  // Handshake: same-cycle for plain ops, only from DONE for mul/div; cancel always kills it.
  always_comb begin
    start    = EXE_valid & (multiply | division) & ~cancel;
    EXE_over = ~cancel & (((state_q == StIdle) & EXE_valid & ~(multiply | division))
                          | (state_q == StDone));
    handoff  = EXE_over & MEM_allow_in;
    EXE_wdest = (EXE_valid & rf_wen & ~cancel) ? rf_wdest : 5'd0;
  end

  // Mul/div FSM next state; divide by zero falls out of the step as q=all-ones, r=|dividend|.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    dsr_d    = dsr_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (multiply) begin
            state_d = StMul;
            cnt_d   = 5'(MUL_CYCLES - 1);
          end else begin
            state_d  = StDiv;
            cnt_d    = 5'd31;
            res_hi_d = 32'h0;
            res_lo_d = abs_a;
            dsr_d    = abs_b;
            qneg_d   = is_signed & (op1[31] ^ op2[31]);
            rneg_d   = is_signed & op1[31];
          end
        end
      end
      StMul: begin
        res_hi_d = product[63:32];
        res_lo_d = product[31:0];
        if (cnt_q == 5'd0) state_d = StDone;
        else               cnt_d   = cnt_q - 5'd1;
      end
      StDiv: begin
        res_hi_d = rem_new;
        res_lo_d = quo_new;
        if (cnt_q == 5'd0) begin
          state_d  = StDone;
          res_hi_d = rneg_q ? (32'h0 - rem_new) : rem_new;
          res_lo_d = qneg_q ? (32'h0 - quo_new) : quo_new;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      StDone: begin
        if (MEM_allow_in) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (cancel) state_d = StIdle;
  end

  // HI/LO only change when the instruction is actually handed to MEM.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (handoff) begin
      if (state_q == StDone) begin
        hi_d = res_hi_q;
        lo_d = res_lo_q;
      end else begin
        if (mthi) hi_d = op1;
        if (mtlo) lo_d = op1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      hi_q     <= 32'h0;
      lo_q     <= 32'h0;
      res_hi_q <= 32'h0;
      res_lo_q <= 32'h0;
      dsr_q    <= 32'h0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      dsr_q    <= dsr_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
    end
  end

  // Result select and outgoing bus.
  logic [31:0] exe_result;
  always_comb begin
    if (mfhi)      exe_result = hi_q;
    else if (mflo) exe_result = lo_q;
    else if (mtc0) exe_result = op2;
    else           exe_result = alu_res;
    EXE_MEM_bus = {mem_control, store_data, exe_result, mtc0, mfc0, cp0r_addr, syscall,
                   break_op, eret, no_inst, j_valid, pc_valid, is_in_delay, rf_wen, rf_wdest,
                   pc};
  end

endmodule

// File: tb/tb_execute.sv
// Directed bench for the EXE stage: ALU ops, HI/LO moves, mul/div latency and results,
// stall, cancel and mid-operation reset.
module tb_execute;

  logic         clk = 1'b0;
  logic         resetn;
  logic         EXE_valid;
  logic [176:0] ID_EXE_bus_r;
  logic         MEM_allow_in;
  logic         cancel;
  logic         EXE_over;
  logic [4:0]   EXE_wdest;
  logic [123:0] EXE_MEM_bus;

  execute #(.MUL_CYCLES(2)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .EXE_valid    (EXE_valid),
    .ID_EXE_bus_r (ID_EXE_bus_r),
    .MEM_allow_in (MEM_allow_in),
    .cancel       (cancel),
    .EXE_over     (EXE_over),
    .EXE_wdest    (EXE_wdest),
    .EXE_MEM_bus  (EXE_MEM_bus)
  );

  always #5 clk = ~clk;

  localparam logic [13:0] ADDU = 14'h1000, SUBU = 14'h0400, SLT = 14'h0200, SLTU = 14'h0100;
  localparam logic [13:0] NOR = 14'h0040, SLL = 14'h0008, SRA = 14'h0002, LUI = 14'h0001;
  localparam logic [13:0] NONE = 14'h0000;
  localparam logic [4:0]  MC = 5'h15;
  localparam logic [31:0] SD = 32'hA5A5_1234, PC = 32'hBFC0_0100;
  localparam logic [7:0]  CP0 = 8'h3C;

  int errors = 0;
  int checks = 0;
  int n;
  int seen;

  function automatic logic [176:0] mk(input logic dv, input logic dvu, input logic mu,
                                      input logic mth, input logic mtl, input logic [13:0] alu,
                                      input logic [31:0] a, input logic [31:0] b,
                                      input logic mfh, input logic mfl, input logic mt0,
                                      input logic [4:0] wd);
    return {dv, dvu, mu, mth, mtl, alu, a, b, MC, SD, mfh, mfl, mt0, 1'b0, CP0, 4'b0101,
            3'b110, (wd != 5'd0), wd, PC};
  endfunction

  function automatic logic [123:0] xbus(input logic mt0, input logic [4:0] wd,
                                        input logic [31:0] res);
    return {MC, SD, res, mt0, 1'b0, CP0, 4'b0101, 3'b110, (wd != 5'd0), wd, PC};
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkbus(input string tag, input logic [123:0] exp);
    checks++;
    assert (EXE_MEM_bus === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, EXE_MEM_bus, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [176:0] b);
    ID_EXE_bus_r = b;
    EXE_valid    = 1'b1;
    #1;
  endtask

  // Plain ALU op: same-cycle handoff and full bus contents.
  task automatic alu_op(input string tag, input logic [13:0] alu, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    issue(mk(0, 0, 0, 0, 0, alu, a, b, 0, 0, 0, 5'd9));
    chk32({tag, "_over"}, 32'(EXE_over), 32'd1);
    chkbus(tag, xbus(1'b0, 5'd9, exp));
    tick();
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
    issue(mk(0, 0, 0, 0, 0, NONE, 32'h0, 32'h0, 1, 0, 0, 5'd2));
    chkbus({tag, "_hi"}, xbus(1'b0, 5'd2, exp_hi));
    tick();
    issue(mk(0, 0, 0, 0, 0, NONE, 32'h0, 32'h0, 0, 1, 0, 5'd2));
    chkbus({tag, "_lo"}, xbus(1'b0, 5'd2, exp_lo));
    tick();
  endtask

  // Wait for EXE_over with a bounded budget; returns the number of edges taken.
  task automatic wait_over(output int cyc);
    cyc = 0;
    while (!EXE_over && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    resetn = 1'b0; EXE_valid = 1'b0; MEM_allow_in = 1'b1; cancel = 1'b0;
    ID_EXE_bus_r = '0;
    tick(); tick();
    chk32("reset_over", 32'(EXE_over), 32'd0);
    resetn = 1'b1;
    tick();
    chk32("idle_over", 32'(EXE_over), 32'd0);
    chk32("idle_wdest", 32'(EXE_wdest), 32'd0);
    read_hilo("reset_hilo", 32'h0, 32'h0);

    // ALU
    issue(mk(0, 0, 0, 0, 0, ADDU, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 5'd9));
    chk32("addu_wdest", 32'(EXE_wdest), 32'd9);
    tick();
    alu_op("addu", ADDU, 32'hFFFF_FFFF, 32'h1, 32'h0);
    alu_op("sra", SRA, 32'd4, 32'h8000_0000, 32'hF800_0000);
    alu_op("slt", SLT, 32'hFFFF_FFFF, 32'h1, 32'h1);
    alu_op("sltu", SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0);
    alu_op("subu", SUBU, 32'd5, 32'd7, 32'hFFFF_FFFE);
    alu_op("lui", LUI, 32'h0, 32'hABCD_1234, 32'h1234_0000);
    alu_op("nor", NOR, 32'h0F0F_0000, 32'h0000_00FF, 32'hF0F0_FF00);
    alu_op("sll", SLL, 32'd4, 32'h1, 32'h10);
    alu_op("none", NONE, 32'h1234, 32'h5678, 32'h0);

    issue(mk(0, 0, 0, 0, 0, NONE, 32'h0, 32'hDEAD_BEEF, 0, 0, 1, 5'd0));
    chkbus("mtc0", xbus(1'b1, 5'd0, 32'hDEAD_BEEF));
    chk32("nowen_wdest", 32'(EXE_wdest), 32'd0);
    tick();

    cancel = 1'b1;
    issue(mk(0, 0, 0, 0, 0, ADDU, 32'h1, 32'h1, 0, 0, 0, 5'd9));
    chk32("cancel_over", 32'(EXE_over), 32'd0);
    chk32("cancel_wdest", 32'(EXE_wdest), 32'd0);
    tick();
    cancel = 1'b0;

    // mthi followed directly by mfhi
    issue(mk(0, 0, 0, 1, 0, NONE, 32'd5, 32'h0, 0, 0, 0, 5'd0));
    tick();
    read_hilo("mthi", 32'd5, 32'h0);

    // mult / multu
    issue(mk(0, 0, 1, 0, 0, NONE, 32'hFFFF_FFFD, 32'd7, 0, 0, 0, 5'd0));
    chk32("mult_over0", 32'(EXE_over), 32'd0);
    wait_over(n);
    chk32("mult_lat", 32'(n), 32'd3);
    tick();
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    issue(mk(0, 1, 1, 0, 0, NONE, 32'hFFFF_FFFD, 32'd7, 0, 0, 0, 5'd0));
    wait_over(n);
    chk32("multu_lat", 32'(n), 32'd3);
    tick();
    read_hilo("multu", 32'd6, 32'hFFFF_FFEB);

    // Signed div with a 5-cycle stall after completion
    MEM_allow_in = 1'b0;
    issue(mk(1, 0, 0, 0, 0, NONE, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 5'd4));
    wait_over(n);
    chk32("div_lat", 32'(n), 32'd33);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk32("stall_over", 32'(EXE_over), 32'd1);
      chkbus("stall_bus", xbus(1'b0, 5'd4, 32'h0));
    end
    MEM_allow_in = 1'b1;
    tick();
    read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(mk(1, 1, 0, 0, 0, NONE, 32'd7, 32'd0, 0, 0, 0, 5'd0));
    wait_over(n);
    chk32("divu0_lat", 32'(n), 32'd33);
    tick();
    read_hilo("divu0", 32'd7, 32'hFFFF_FFFF);

    // Cancel in the middle of a divide
    issue(mk(0, 0, 0, 1, 1, NONE, 32'd11, 32'h0, 0, 0, 0, 5'd0));
    tick();
    issue(mk(1, 0, 0, 0, 0, NONE, 32'd100, 32'd3, 0, 0, 0, 5'd7));
    chk32("divc_wdest", 32'(EXE_wdest), 32'd7);
    for (int i = 0; i < 10; i++) tick();
    cancel = 1'b1;
    #1;
    chk32("divc_over", 32'(EXE_over), 32'd0);
    chk32("divc_wdest0", 32'(EXE_wdest), 32'd0);
    tick();
    cancel = 1'b0;
    issue(mk(0, 0, 0, 0, 0, ADDU, 32'd2, 32'd3, 0, 0, 0, 5'd9));
    chk32("divc_idle", 32'(EXE_over), 32'd1);
    chkbus("divc_addu", xbus(1'b0, 5'd9, 32'd5));
    tick();
    EXE_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (EXE_over) seen++;
    end
    chk32("divc_noresume", 32'(seen), 32'd0);
    read_hilo("divc", 32'd11, 32'd11);

    // Reset in the middle of a multiply clears HI/LO
    issue(mk(0, 0, 1, 0, 0, NONE, 32'd3, 32'd3, 0, 0, 0, 5'd0));
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    EXE_valid = 1'b0;
    #1;
    chk32("rst_over", 32'(EXE_over), 32'd0);
    tick();
    read_hilo("rst", 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
